// File: rtl/microaddr.sv
// Shared micro-address counter command encoding used by the sequencer and the counter.
package microaddr;
  localparam int unsigned ADDR_W = 11;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_LOAD = 2'd2
  } cmd_e;
endpackage

// File: rtl/microseq_ctrl.sv
// Microcode sequencer: decodes the microword sequencing field into counter cmd/load_addr.
// Define MICROSEQ_STACK_GUARD_EN to trap return-stack overflow/underflow into HALT with stack_err.
module microseq_ctrl
  import microaddr::*;
#(
  parameter int unsigned STACK_DEPTH    = 4,
  parameter int unsigned DISPATCH_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        seq_op,
  input  logic [ADDR_W-1:0] target,
  input  logic [1:0]        cond_sel,
  input  logic [2:0]        flags,
  input  logic [7:0]        opcode,
  input  logic              mem_ready,
  input  logic              resume,
  output cmd_e              cmd,
  output logic [ADDR_W-1:0] load_addr,
  output logic              halted,
  output logic              stack_err
);

  localparam int unsigned IDXW = $clog2(STACK_DEPTH);
  localparam int unsigned SPW  = IDXW + 1;

  localparam logic [2:0] OP_CONT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_JCOND    = 3'd2;
  localparam logic [2:0] OP_DISPATCH = 3'd3;
  localparam logic [2:0] OP_CALL     = 3'd4;
  localparam logic [2:0] OP_RET      = 3'd5;
  localparam logic [2:0] OP_WAIT     = 3'd6;
  localparam logic [2:0] OP_HALT     = 3'd7;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic              halted_q, halted_d;
  logic              stack_err_q, stack_err_d;

  cmd_e              cmd_c;
  logic [ADDR_W-1:0] load_addr_c;
  logic              cond_true;
  logic              stack_full;
  logic              stack_empty;
  logic [IDXW-1:0]   push_idx;
  logic [IDXW-1:0]   pop_idx;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] opcode_ext;

  // flags = {negative, carry, zero}
  always_comb begin
    case (cond_sel)
      2'd0:    cond_true = flags[0];
      2'd1:    cond_true = flags[1];
      2'd2:    cond_true = flags[2];
      default: cond_true = 1'b1;
    endcase
  end

  // sp==0 pops index STACK_DEPTH-1 and sp==STACK_DEPTH pushes index 0 through the natural wrap.
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_idx    = IDXW'(sp_q);
  assign pop_idx     = IDXW'(sp_q - SPW'(1));
  assign ret_addr    = addr + ADDR_W'(1);
  assign opcode_ext  = ADDR_W'(opcode);

  always_comb begin
    cmd_c       = CMD_NONE;
    load_addr_c = '0;
    state_d     = state_q;
    sp_d        = sp_q;
    stack_d     = stack_q;
    stack_err_d = stack_err_q;

    if (state_q == S_RUN) begin
      case (seq_op)
        OP_CONT: cmd_c = CMD_INC;
        OP_JUMP: begin
          cmd_c       = CMD_LOAD;
          load_addr_c = target;
        end
        OP_JCOND: begin
          if (cond_true) begin
            cmd_c       = CMD_LOAD;
            load_addr_c = target;
          end else begin
            cmd_c = CMD_INC;
          end
        end
        OP_DISPATCH: begin
          cmd_c       = CMD_LOAD;
          load_addr_c = opcode_ext << DISPATCH_SHIFT;
        end
        OP_CALL: begin
`ifdef MICROSEQ_STACK_GUARD_EN
          if (stack_full) begin
            stack_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            cmd_c             = CMD_LOAD;
            load_addr_c       = target;
            stack_d[push_idx] = ret_addr;
            sp_d              = sp_q + SPW'(1);
          end
`else
          cmd_c             = CMD_LOAD;
          load_addr_c       = target;
          stack_d[push_idx] = ret_addr;
          sp_d              = stack_full ? '0 : sp_q + SPW'(1);
`endif
        end
        OP_RET: begin
`ifdef MICROSEQ_STACK_GUARD_EN
          if (stack_empty) begin
            stack_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            cmd_c       = CMD_LOAD;
            load_addr_c = stack_q[pop_idx];
            sp_d        = sp_q - SPW'(1);
          end
`else
          cmd_c       = CMD_LOAD;
          load_addr_c = stack_q[pop_idx];
          sp_d        = stack_empty ? SPW'(STACK_DEPTH - 1) : sp_q - SPW'(1);
`endif
        end
        OP_WAIT: cmd_c = mem_ready ? CMD_INC : CMD_NONE;
        OP_HALT: state_d = S_HALT;
        default: cmd_c = CMD_NONE;
      endcase
    end else if (resume) begin
      cmd_c   = CMD_INC;
      state_d = S_RUN;
    end

    halted_d = (state_d == S_HALT);

    // Counter must see no command while reset is held.
    if (!reset) begin
      cmd_c       = CMD_NONE;
      load_addr_c = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      sp_q        <= '0;
      halted_q    <= 1'b0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      halted_q    <= halted_d;
      stack_err_q <= stack_err_d;
      stack_q     <= stack_d;
    end
  end

  assign cmd       = cmd_c;
  assign load_addr = load_addr_c;
  assign halted    = halted_q;
`ifdef MICROSEQ_STACK_GUARD_EN
  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_microseq_ctrl.sv
// Scoreboard bench for microseq_ctrl driving a behavioural micro-address counter.
module tb_microseq_ctrl;
  import microaddr::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] addr;
  logic [2:0]  seq_op;
  logic [10:0] target;
  logic [1:0]  cond_sel;
  logic [2:0]  flags;
  logic [7:0]  opcode;
  logic        mem_ready;
  logic        resume;
  cmd_e        cmd;
  logic [10:0] load_addr;
  logic        halted;
  logic        stack_err;

  typedef struct {
    string       name;
    cmd_e        cmd;
    logic [10:0] la;
    logic        h;
    logic        e;
    logic [10:0] a;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  microseq_ctrl #(.STACK_DEPTH(4), .DISPATCH_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .addr(addr), .seq_op(seq_op), .target(target),
    .cond_sel(cond_sel), .flags(flags), .opcode(opcode), .mem_ready(mem_ready),
    .resume(resume), .cmd(cmd), .load_addr(load_addr), .halted(halted),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Behavioural microaddr_counter closing the address loop.
  always @(posedge clk or negedge reset) begin
    if (!reset) addr <= '0;
    else if (cmd == CMD_LOAD) addr <= load_addr;
    else if (cmd == CMD_INC) addr <= addr + 11'd1;
  end

  // Monitor: outputs are presented every cycle, so pop one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_checks++;
      if (cmd !== x.cmd || load_addr !== x.la || halted !== x.h ||
          stack_err !== x.e || addr !== x.a) begin
        n_fail++;
        $display("FAIL %s: got cmd=%0d la=%h halted=%b err=%b addr=%h, want cmd=%0d la=%h halted=%b err=%b addr=%h",
                 x.name, cmd, load_addr, halted, stack_err, addr,
                 x.cmd, x.la, x.h, x.e, x.a);
      end
    end
  end

  task automatic step(input string n, input cmd_e c, input logic [10:0] la,
                      input logic h, input logic e, input logic [10:0] a);
    exp_t x;
    x.name = n; x.cmd = c; x.la = la; x.h = h; x.e = e; x.a = a;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [10:0] t);
    seq_op = o;
    target = t;
  endtask

  initial begin
    reset = 1'b0; seq_op = 3'd0; target = '0; cond_sel = '0; flags = '0;
    opcode = '0; mem_ready = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    op(3'd0, 11'h000); step("cont",      CMD_INC,  11'h000, 0, 0, 11'h000);
    op(3'd1, 11'h123); step("jump",      CMD_LOAD, 11'h123, 0, 0, 11'h001);
    reset = 1'b0;      step("rst_mid",   CMD_NONE, 11'h000, 0, 0, 11'h000);
    reset = 1'b1;
    op(3'd0, 11'h000); step("rst_rel",   CMD_INC,  11'h000, 0, 0, 11'h000);
    op(3'd1, 11'h010); step("jmp_010",   CMD_LOAD, 11'h010, 0, 0, 11'h001);
    op(3'd4, 11'h200); step("call",      CMD_LOAD, 11'h200, 0, 0, 11'h010);
    op(3'd5, 11'h000); step("ret",       CMD_LOAD, 11'h011, 0, 0, 11'h200);

    opcode = 8'hA5;
    op(3'd3, 11'h000); step("dispatch",  CMD_LOAD, 11'h528, 0, 0, 11'h011);
    cond_sel = 2'd0; flags = 3'b001;
    op(3'd2, 11'h050); step("jcond_z1",  CMD_LOAD, 11'h050, 0, 0, 11'h528);
    flags = 3'b000;    step("jcond_z0",  CMD_INC,  11'h000, 0, 0, 11'h050);
    cond_sel = 2'd1; flags = 3'b010;
    op(3'd2, 11'h060); step("jcond_c1",  CMD_LOAD, 11'h060, 0, 0, 11'h051);
    cond_sel = 2'd2; flags = 3'b011;
    op(3'd2, 11'h7F0); step("jcond_n0",  CMD_INC,  11'h000, 0, 0, 11'h060);
    cond_sel = 2'd3; flags = 3'b000;
    op(3'd2, 11'h070); step("jcond_alw", CMD_LOAD, 11'h070, 0, 0, 11'h061);

    mem_ready = 1'b0;
    op(3'd6, 11'h000);
    for (int i = 0; i < 3; i++) step("wait_lo", CMD_NONE, 11'h000, 0, 0, 11'h070);
    mem_ready = 1'b1;  step("wait_hi",   CMD_INC,  11'h000, 0, 0, 11'h070);

    op(3'd7, 11'h000); step("halt",      CMD_NONE, 11'h000, 0, 0, 11'h071);
    op(3'd1, 11'h3FF);
    for (int i = 0; i < 5; i++) step("halted", CMD_NONE, 11'h000, 1, 0, 11'h071);
    resume = 1'b1;     step("resume",    CMD_INC,  11'h000, 1, 0, 11'h071);
    resume = 1'b0;
    op(3'd0, 11'h000); step("run_again", CMD_INC,  11'h000, 0, 0, 11'h072);

    op(3'd1, 11'h7FF); step("jmp_7ff",   CMD_LOAD, 11'h7FF, 0, 0, 11'h073);
    op(3'd4, 11'h100); step("call_wrap", CMD_LOAD, 11'h100, 0, 0, 11'h7FF);
    op(3'd5, 11'h000); step("ret_wrap",  CMD_LOAD, 11'h000, 0, 0, 11'h100);

    op(3'd4, 11'h100); step("call1",     CMD_LOAD, 11'h100, 0, 0, 11'h000);
    op(3'd4, 11'h200); step("call2",     CMD_LOAD, 11'h200, 0, 0, 11'h100);
    op(3'd4, 11'h300); step("call3",     CMD_LOAD, 11'h300, 0, 0, 11'h200);
    op(3'd4, 11'h400); step("call4",     CMD_LOAD, 11'h400, 0, 0, 11'h300);
`ifdef MICROSEQ_STACK_GUARD_EN
    op(3'd4, 11'h500); step("call5_ovf", CMD_NONE, 11'h000, 0, 0, 11'h400);
    op(3'd0, 11'h000); step("ovf_halt",  CMD_NONE, 11'h000, 1, 1, 11'h400);
    resume = 1'b1;     step("ovf_res",   CMD_INC,  11'h000, 1, 1, 11'h400);
    resume = 1'b0;     step("err_stick", CMD_INC,  11'h000, 0, 1, 11'h401);
    reset = 1'b0;      step("rst_err",   CMD_NONE, 11'h000, 0, 0, 11'h000);
    reset = 1'b1;
    op(3'd5, 11'h000); step("ret_udf",   CMD_NONE, 11'h000, 0, 0, 11'h000);
    op(3'd0, 11'h000); step("udf_halt",  CMD_NONE, 11'h000, 1, 1, 11'h000);
`else
    op(3'd4, 11'h500); step("call5_wrp", CMD_LOAD, 11'h500, 0, 0, 11'h400);
    op(3'd5, 11'h000); step("ret_udf",   CMD_LOAD, 11'h301, 0, 0, 11'h500);
    step("ret_sp3",   CMD_LOAD, 11'h201, 0, 0, 11'h301);
    step("ret_sp2",   CMD_LOAD, 11'h101, 0, 0, 11'h201);
    step("ret_sp1",   CMD_LOAD, 11'h401, 0, 0, 11'h101);
    op(3'd0, 11'h000); step("after_ret", CMD_INC,  11'h000, 0, 0, 11'h401);
`endif

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
